// File: rtl/pfft_mul_pipe_if.sv
// pfft_mul_pipe_if -- operand/result handshake bundle for pfft_mul_pipe.
//
// Input side : in_valid, in_ready, din0 (signed operand A), din1 (signed operand B)
// Output side: out_valid, out_ready, dout (signed result), ovf (saturation flag)
//
// Modports:
//   master - the producer/consumer around the multiplier (drives operands and out_ready)
//   slave  - the multiplier itself
interface pfft_mul_pipe_if #(
  parameter int DIN0_WIDTH = 13,
  parameter int DIN1_WIDTH = 71,
  parameter int DOUT_WIDTH = 71
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface

// File: rtl/pfft_mul_pipe.sv
// pfft_mul_pipe -- pipelined signed multiplier with half-up rounding shift and
// optional output saturation, valid/ready on both sides.
//
// Ports:
//   ap_clk    - clock, rising edge
//   ap_rst_n  - asynchronous active-low reset
//   bus       - pfft_mul_pipe_if.slave: in_valid/in_ready/din0/din1 operand side,
//               out_valid/out_ready/dout/ovf result side
//
// Parameters: DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, NUM_STAGE (1..8), SHIFT.
//
// Build option: define PFFT_MUL_SAT_EN to clamp the rounded result to the
// DOUT_WIDTH signed range and flag clamping on ovf. Without it the result
// wraps to the low DOUT_WIDTH bits and ovf is constant 0.
//
// Pipeline: stage 0 .. NUM_STAGE-2 carry the full product, the last stage
// holds the rounded/narrowed result. Each stage has its own valid flag so
// bubbles collapse; a stage loads whenever it is empty or everything
// downstream of it can move.
module pfft_mul_pipe #(
  parameter int DIN0_WIDTH = 13,
  parameter int DIN1_WIDTH = 71,
  parameter int DOUT_WIDTH = 71,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0
) (
  input logic             ap_clk,
  input logic             ap_rst_n,
  pfft_mul_pipe_if.slave  bus
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
  // Working width for rounding: at least one bit above the product, and at
  // least one bit above the output so the range check always has a guard bit.
  localparam int EW  = (PW + 1 > DOUT_WIDTH) ? PW + 1 : DOUT_WIDTH + 1;
  localparam int SH1 = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [EW-1:0] RND = (SHIFT == 0) ? '0 : ({{(EW-1){1'b0}}, 1'b1} << SH1);

  logic [NUM_STAGE-1:0] vld;
  logic [NUM_STAGE-1:0] adv;
  logic [NUM_STAGE:0]   vchain;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] last_in;

  logic signed [EW-1:0] pext;
  logic signed [EW-1:0] rsum;
  logic signed [EW-1:0] rval;

  logic [DOUT_WIDTH-1:0] res;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic                  unused_bits;

  // Stage k may move iff out_ready, or some stage at or after k is empty.
  // Built from a running AND instead of chaining adv[k] on adv[k+1].
  always_comb begin : adv_calc
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int unsigned i = 0; i < NUM_STAGE; i++) begin
      all_full                = all_full & vld[NUM_STAGE-1-i];
      adv[NUM_STAGE-1-i]      = bus.out_ready | ~all_full;
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[NUM_STAGE-1];

  // vchain[k] is the valid entering stage k.
  assign vchain = {vld, bus.in_valid};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_STAGE; k++) begin
        if (adv[k]) vld[k] <= vchain[k];
      end
    end
  end

  always_comb begin
    a_ext = PW'($signed(bus.din0));
    b_ext = PW'($signed(bus.din1));
    prod  = a_ext * b_ext;
  end

  generate
    if (NUM_STAGE == 1) begin : g_nopipe
      always_comb last_in = prod;
    end else begin : g_pipe
      logic [NUM_STAGE-2:0][PW-1:0] pr;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          pr <= '0;
        end else begin
          if (adv[0]) pr[0] <= prod;
          for (int unsigned k = 1; k < NUM_STAGE - 1; k++) begin
            if (adv[k]) pr[k] <= pr[k-1];
          end
        end
      end

      always_comb last_in = pr[NUM_STAGE-2];
    end
  endgenerate

  // Half-up rounding: add 2^(SHIFT-1) in the widened domain, then arithmetic
  // shift. With SHIFT=0 the constant is zero and the shift is a no-op.
  always_comb begin
    pext = EW'(last_in);
    rsum = pext + $signed(RND);
    rval = rsum >>> SHIFT;
  end

`ifdef PFFT_MUL_SAT_EN
  logic in_range;
  logic res_ovf;
  logic ovf_q;

  // In range iff every bit from the output sign bit upward agrees.
  always_comb begin
    in_range = (&rval[EW-1:DOUT_WIDTH-1]) | ~(|rval[EW-1:DOUT_WIDTH-1]);
    res_ovf  = ~in_range;
    if (in_range)       res = rval[DOUT_WIDTH-1:0];
    else if (rval[EW-1]) res = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
    else                res = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv[NUM_STAGE-1]) begin
      ovf_q <= res_ovf;
    end
  end

  // Flag register follows the data gating; mask so it reads 0 when empty.
  assign bus.ovf = ovf_q & vld[NUM_STAGE-1];
`else
  always_comb res = rval[DOUT_WIDTH-1:0];

  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q <= '0;
    end else if (adv[NUM_STAGE-1]) begin
      dout_q <= res;
    end
  end

  assign bus.dout = dout_q;

  always_comb unused_bits = ^{vchain[NUM_STAGE], rval[EW-1:DOUT_WIDTH]};

endmodule

// File: tb/tb_pfft_mul_pipe.sv
// tb_pfft_mul_pipe -- self-checking bench for pfft_mul_pipe with
// DIN0=8, DIN1=8, DOUT=8, SHIFT=4, NUM_STAGE=3. Expected results come from an
// integer reference model and are queued on acceptance, popped on delivery.
// Honours PFFT_MUL_SAT_EN in the reference model.
module tb_pfft_mul_pipe;

  localparam int D0 = 8;
  localparam int D1 = 8;
  localparam int DO = 8;
  localparam int NS = 3;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pfft_mul_pipe_if #(.DIN0_WIDTH(D0), .DIN1_WIDTH(D1), .DOUT_WIDTH(DO)) bus ();

  pfft_mul_pipe #(
    .DIN0_WIDTH(D0),
    .DIN1_WIDTH(D1),
    .DOUT_WIDTH(DO),
    .NUM_STAGE (NS),
    .SHIFT     (SH)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DO:0] sbq[$];  // {ovf, dout}

  function automatic logic [DO:0] model(input int a, input int b);
    int p, r, hi, lo;
    logic [DO-1:0] d;
    logic o;
    p  = a * b;
    r  = (p + (1 << (SH - 1))) >>> SH;
    hi = (1 << (DO - 1)) - 1;
    lo = -(1 << (DO - 1));
`ifdef PFFT_MUL_SAT_EN
    if (r > hi) begin
      d = DO'(hi); o = 1'b1;
    end else if (r < lo) begin
      d = DO'(lo); o = 1'b1;
    end else begin
      d = DO'(r); o = 1'b0;
    end
`else
    d = DO'(r);
    o = 1'b0;
    if (hi < lo) o = 1'b1;  // unreachable, keeps hi/lo referenced in both builds
`endif
    return {o, d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", bus.dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single(input int a, input int b, input string name);
    logic [DO:0] e;
    int lat;
    bus.din0 = D0'(a);
    bus.din1 = D1'(b);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept: in_ready got %b expected 1", name, bus.in_ready); end
    if (bus.in_ready === 1'b1) sbq.push_back(model(a, b));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != NS) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, NS); end
    e = (sbq.size() > 0) ? sbq.pop_front() : '1;
    checks++; if (bus.dout !== e[DO-1:0]) begin errors++; $display("FAIL %s_dout: got %0d expected %0d", name, $signed(bus.dout), $signed(e[DO-1:0])); end
    checks++; if (bus.ovf !== e[DO]) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, bus.ovf, e[DO]); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: out_valid got %b expected 0", name, bus.out_valid); end
  endtask

  task automatic test_backpressure();
    int sent, got, a, b;
    logic hv, ho;
    logic [DO-1:0] hd;
    logic [DO:0] e;
    bit saw_stall;
    sent = 0; got = 0; hv = 1'b0; ho = 1'b0; hd = '0; saw_stall = 1'b0; a = 0; b = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 8);
      if (sent < 10) begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        bus.din0 = D0'(a);
        bus.din1 = D1'(b);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (hv) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.dout !== hd || bus.ovf !== ho) begin
          errors++; $display("FAIL bp_hold: got v=%b d=%0d o=%b expected v=1 d=%0d o=%b", bus.out_valid, bus.dout, bus.ovf, hd, ho);
        end
      end
      if (sbq.size() == NS && !bus.out_ready) begin
        saw_stall = 1'b1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_stall: in_ready got %b expected 0", bus.in_ready); end
      end
      if (sbq.size() == NS && bus.out_ready) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_accept: in_ready got %b expected 1", bus.in_ready); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        e = (sbq.size() > 0) ? sbq.pop_front() : '1;
        got++;
        checks++; if (bus.dout !== e[DO-1:0] || bus.ovf !== e[DO]) begin
          errors++; $display("FAIL bp_result%0d: got d=%0d o=%b expected d=%0d o=%b", got, $signed(bus.dout), bus.ovf, $signed(e[DO-1:0]), e[DO]);
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        sbq.push_back(model(a, b));
        sent++;
      end
      hv = (bus.out_valid === 1'b1) && !bus.out_ready;
      hd = bus.dout;
      ho = bus.ovf;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 10) begin errors++; $display("FAIL bp_count: got %0d expected 10", got); end
    checks++; if (!saw_stall) begin errors++; $display("FAIL bp_stall_seen: got 0 expected 1"); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d expected 0", sbq.size()); end
  endtask

  task automatic test_back_to_back();
    int sent, got, a, b;
    logic [DO:0] e;
    sent = 0; got = 0; a = 0; b = 0;
    for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
      bus.out_ready = ($urandom_range(0, 9) < 6);
      if (sent < 40 && $urandom_range(0, 9) < 7) begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        bus.din0 = D0'(a);
        bus.din1 = D1'(b);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid !== 1'b1) begin
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf_idle: got %b expected 0", bus.ovf); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        e = (sbq.size() > 0) ? sbq.pop_front() : '1;
        got++;
        checks++; if (bus.dout !== e[DO-1:0] || bus.ovf !== e[DO]) begin
          errors++; $display("FAIL b2b_result%0d: got d=%0d o=%b expected d=%0d o=%b", got, $signed(bus.dout), bus.ovf, $signed(e[DO-1:0]), e[DO]);
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        sbq.push_back(model(a, b));
        sent++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 40) begin errors++; $display("FAIL b2b_count: got %0d expected 40", got); end
  endtask

  task automatic test_reset_flight();
    int seen;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.din0 = D0'(i + 1);
      bus.din1 = D1'(7);
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready === 1'b1) sbq.push_back(model(i + 1, 7));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rf_pre_valid: got %b expected 1", bus.out_valid); end
    checks++; if (sbq.size() != 2) begin errors++; $display("FAIL rf_in_flight: got %0d expected 2", sbq.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rf_async_clear: out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL rf_dout_clear: got %0d expected 0", bus.dout); end
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready: got %b expected 1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rf_stale: got %0d results expected 0", seen); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single(3, 5, "pos");
    test_single(-3, 5, "neg");
    test_single(-128, -128, "corner");
    test_backpressure();
    test_back_to_back();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
